wb_select_queue: RTL and testbench
==================================

# wb_select_queue

Parametrised write-back selector and buffer for the MIPS datapath. Picks one of `NUM_SRC` candidate write-back words by `sel` and queues the word with its destination register address in a small FIFO. Drains the FIFO into the register-file write port under a ready handshake. Sits between the execute/memory result sources (ALU out, EPC, MDR, compare, shifter, PC, HI/LO, …) and the register file, so a busy write port stalls write-back without losing results.

## Interface
Parameters:
- `DATA_W`, 32, width of each source and of write data
- `NUM_SRC`, 8, number of selectable sources (≥2)
- `SEL_W`, `$clog2(NUM_SRC)`, select width
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `ADDR_W`, 5, register-address width

Ports:
- `clk` in 1: the single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `src_data` in `NUM_SRC*DATA_W`: flattened sources; source i at bits `[i*DATA_W +: DATA_W]`
- `sel` in `SEL_W`: source index
- `wr_addr` in `ADDR_W`: destination register
- `wr_valid` in 1: write-back request
- `wr_ready` out 1: FIFO can accept; equals `!full`
- `rf_we` out 1: head entry valid toward register file
- `rf_addr` out `ADDR_W`: head destination
- `rf_data` out `DATA_W`: head data
- `rf_ready` in 1: register file accepts head this cycle
- `full`, `empty` out 1: FIFO status
- `count` out `$clog2(DEPTH)+1`: occupancy
- `sel_err` out 1: sticky; a push used `sel >= NUM_SRC`
- `fwd_addr` in `ADDR_W`: forwarding lookup address
- `fwd_hit` out 1: queued entry matches `fwd_addr`
- `fwd_data` out `DATA_W`: data of the youngest matching entry

## Operation
- Push: `wr_valid && wr_ready` at a rising edge.
  - If `wr_addr != 0`: write `{wr_addr, src_data[sel]}` at the tail and advance the tail.
  - If `wr_addr == 0`: accept the request but discard it. Register $zero is never written; the tail is unchanged.
- `sel >= NUM_SRC` on a push: the data word is all zeros and `sel_err` is set. `sel_err` clears only on reset.
- `wr_valid` while full: the request is not accepted; the source holds it.
- Pop: `rf_we && rf_ready`. The head advances.
- `rf_we = !empty`.
  - `rf_addr` and `rf_data` come straight from the head entry.
  - When empty, `rf_addr` and `rf_data` are 0.
- Simultaneous push and pop:
  - Allowed whenever not full; `count` is unchanged.
  - When full, no push occurs because `wr_ready = 0`, even if a pop occurs in the same cycle. There is no same-cycle pass-through.
- Pointers are `$clog2(DEPTH)` bits and wrap from `DEPTH-1` to 0.
- `count` is kept consistent with the pointers: `full = (count == DEPTH)`, `empty = (count == 0)`.
- No entry ever bypasses storage.

## Timing
- Reset (asynchronous, on the falling edge of `reset_n`):
  - Pointers, `count` and `sel_err` go to 0.
  - `empty = 1`; `full`, `rf_we`, `rf_addr`, `rf_data`, `fwd_hit` and `fwd_data` go to 0; `wr_ready = 1`.
  - Reset mid-operation flushes all queued entries immediately, without waiting for a clock.
- Push-to-`rf_we` latency: 1 cycle, meaning the entry is visible in the cycle after the accepting edge.
- Minimum latency from push to register-file write: 1 cycle.
- Throughput: 1 push and 1 pop per cycle.
- Status outputs (`full`, `empty`, `count`, `wr_ready`) update at the edge where the push or pop takes effect.
- Forwarding path is combinational from `fwd_addr` and the stored entries. Entries being pushed in the current cycle are not visible to it.

## Configuration
- `WB_QUEUE_FWD_EN` defined:
  - Forwarding search is compiled in. It scans valid entries from tail-1 back to head.
  - `fwd_hit = 1` and `fwd_data` is set to the youngest entry with `rf_addr == fwd_addr`.
  - `fwd_addr == 0` always gives `fwd_hit = 0`.
- Undefined: the ports remain present; `fwd_hit` and `fwd_data` are tied to 0 and no search logic is built.

## Test plan
- Reset, then push `sel=2`, `wr_addr=9` with source 2 = 0xDEADBEEF, `rf_ready=0` -> next cycle `rf_we=1`, `rf_addr=9`, `rf_data=0xDEADBEEF`, `count=1`. Raise `rf_ready` -> cycle after: `empty=1`, `rf_we=0`.
- Push 4 entries (`DEPTH=4`) with `rf_ready=0` -> `full=1`, `wr_ready=0`. A 5th `wr_valid` is held. Drain with `rf_ready=1` -> data emerges in push order over 4 cycles.
- Continuous push and pop for 10 cycles starting at `count=2` -> `count` stays 2, no loss or duplication across pointer wrap.
- Push with `wr_addr=0` -> `count` unchanged, `rf_we` stays 0. Push with `sel=7` when `NUM_SRC=6` -> `rf_data=0`, `sel_err=1` until reset.
- With `WB_QUEUE_FWD_EN`: queue r5=0x11 then r5=0x22, `fwd_addr=5` -> `fwd_hit=1`, `fwd_data=0x22`. Without the macro -> `fwd_hit=0`.
- Drop `reset_n` while holding 3 entries, between clock edges -> outputs reach their reset values immediately. After release, the first push appears with `count=1`.

Source files
------------

// File: rtl/wb_select_queue.sv
// Write-back source selector feeding a small register-file write queue.
// Define WB_QUEUE_FWD_EN to build the youngest-match forwarding search.
module wb_select_queue #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_data,
  input  logic                      rf_ready,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      sel_err,
  input  logic [ADDR_W-1:0]         fwd_addr,
  output logic                      fwd_hit,
  output logic [DATA_W-1:0]         fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Out-of-range selects yield an all-zero word rather than an undefined slice.
  function automatic logic [DATA_W-1:0] pick_src(
    input logic [NUM_SRC*DATA_W-1:0] srcs,
    input logic [SEL_W-1:0]          s
  );
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w = (int'(s) == i) ? srcs[i*DATA_W +: DATA_W] : w;
    end
    return w;
  endfunction

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sel_err_q, sel_err_d;

  logic              push_s;
  logic              store_s;
  logic              pop_s;
  logic              sel_bad_s;
  logic [DATA_W-1:0] sel_word_s;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == {CNT_W{1'b0}});
  assign count      = count_q;
  assign wr_ready   = !full;
  assign sel_err    = sel_err_q;
  assign rf_we      = !empty;

  assign sel_bad_s  = (int'(sel) >= NUM_SRC);
  assign sel_word_s = pick_src(src_data, sel);
  assign push_s     = wr_valid && wr_ready;
  assign store_s    = push_s && (wr_addr != {ADDR_W{1'b0}});
  assign pop_s      = rf_we && rf_ready;

  // Head entry drives the register-file port directly; zeros when idle.
  always_comb begin
    rf_addr = '0;
    rf_data = '0;
    if (!empty) begin
      rf_addr = addr_mem_q[rd_ptr_q];
      rf_data = data_mem_q[rd_ptr_q];
    end else begin
      rf_addr = '0;
      rf_data = '0;
    end
  end

  // Pointer, occupancy and sticky error next-state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    sel_err_d = sel_err_q | (push_s & sel_bad_s);
    if (store_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({store_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset flushes the queue without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sel_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Entry storage; contents only matter while covered by count, so no reset.
  always_ff @(posedge clk) begin
    if (store_s) begin
      addr_mem_q[wr_ptr_q] <= wr_addr;
      data_mem_q[wr_ptr_q] <= sel_word_s;
    end
  end

`ifdef WB_QUEUE_FWD_EN
  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) && (fwd_addr != {ADDR_W{1'b0}}) &&
          (addr_mem_q[rd_ptr_q + PTR_W'(k)] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem_q[rd_ptr_q + PTR_W'(k)];
      end else begin
        fwd_hit  = fwd_hit;
        fwd_data = fwd_data;
      end
    end
  end
`else
  logic unused_fwd_addr_s;
  assign unused_fwd_addr_s = ^fwd_addr;
  assign fwd_hit           = 1'b0;
  assign fwd_data          = '0;
`endif

endmodule

// File: tb/tb_wb_select_queue.sv
// Scoreboard bench for wb_select_queue (DEPTH=4, NUM_SRC=6).
module tb_wb_select_queue;

  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 6;
  localparam int SEL_W   = $clog2(NUM_SRC);
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic                      clk;
  logic                      reset_n;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [SEL_W-1:0]          sel;
  logic [ADDR_W-1:0]         wr_addr;
  logic                      wr_valid;
  logic                      wr_ready;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_addr;
  logic [DATA_W-1:0]         rf_data;
  logic                      rf_ready;
  logic                      full;
  logic                      empty;
  logic [$clog2(DEPTH):0]    count;
  logic                      sel_err;
  logic [ADDR_W-1:0]         fwd_addr;
  logic                      fwd_hit;
  logic [DATA_W-1:0]         fwd_data;

  entry_t sb[$];
  logic   m_sel_err;
  int     checks;
  int     failures;

  wb_select_queue #(
    .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .src_data(src_data), .sel(sel), .wr_addr(wr_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_data(rf_data), .rf_ready(rf_ready), .full(full), .empty(empty), .count(count),
    .sel_err(sel_err), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] exp_word(input logic [SEL_W-1:0] s);
    logic [DATA_W-1:0] w;
    w = '0;
    if (int'(s) < NUM_SRC) w = src_data[int'(s)*DATA_W +: DATA_W];
    return w;
  endfunction

  // One clock: update the model from the driven inputs, checking any popped head.
  task automatic tick();
    logic   do_pop;
    logic   do_push;
    entry_t e;
    do_pop  = rf_ready && (sb.size() > 0);
    do_push = wr_valid && (sb.size() < DEPTH);
    if (do_pop) begin
      e = sb.pop_front();
      checks++;
      if (rf_we !== 1'b1 || rf_addr !== e.addr || rf_data !== e.data) begin
        failures++;
        $display("FAIL pop_head got we=%b addr=%0d data=%h exp addr=%0d data=%h",
                 rf_we, rf_addr, rf_data, e.addr, e.data);
      end
    end
    if (do_push) begin
      if (int'(sel) >= NUM_SRC) m_sel_err = 1'b1;
      if (wr_addr != 5'd0) sb.push_back({wr_addr, exp_word(sel)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [SEL_W-1:0] s, input logic [ADDR_W-1:0] a);
    wr_valid = 1'b1;
    sel      = s;
    wr_addr  = a;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    rf_ready = 1'b1;
    for (int i = 0; i < 12 && sb.size() > 0; i++) tick();
    rf_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || sb.size() != 0) begin
      failures++;
      $display("FAIL drain_empty got empty=%b model_left=%0d exp empty=1", empty, sb.size());
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    rf_ready = 1'b0;
    sel      = '0;
    wr_addr  = '0;
    fwd_addr = '0;
    for (int i = 0; i < NUM_SRC; i++) src_data[i*DATA_W +: DATA_W] = 32'hA000_0000 + 32'(i * 17);
    #12;
    checks++;
    if ({rf_we, full, empty, wr_ready, sel_err, fwd_hit} !== 6'b001100 || count !== 3'd0) begin
      failures++;
      $display("FAIL reset_status got we,full,empty,rdy,err,hit=%b count=%0d exp 001100 count=0",
               {rf_we, full, empty, wr_ready, sel_err, fwd_hit}, count);
    end
    checks++;
    if (rf_addr !== 5'd0 || rf_data !== 32'd0 || fwd_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got addr=%0d data=%h fwd=%h exp 0", rf_addr, rf_data, fwd_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    src_data[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    push(3'd2, 5'd9);
    checks++;
    if (rf_we !== 1'b1 || rf_addr !== 5'd9 || rf_data !== 32'hDEAD_BEEF || count !== 3'd1) begin
      failures++;
      $display("FAIL single_visible got we=%b addr=%0d data=%h count=%0d exp 1 9 deadbeef 1",
               rf_we, rf_addr, rf_data, count);
    end
    rf_ready = 1'b1;
    tick();
    rf_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL single_drained got empty=%b we=%b exp 1 0", empty, rf_we);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      src_data[i*DATA_W +: DATA_W] = 32'h1000_0000 + 32'(i * 32'h0101);
      push(3'(i), 5'(10 + i));
    end
    checks++;
    if (full !== 1'b1 || wr_ready !== 1'b0 || count !== 3'd4) begin
      failures++;
      $display("FAIL fill_full got full=%b rdy=%b count=%0d exp 1 0 4", full, wr_ready, count);
    end
    wr_valid = 1'b1;
    sel      = 3'd5;
    wr_addr  = 5'd20;
    tick();
    checks++;
    if (count !== 3'd4 || rf_addr !== 5'd10) begin
      failures++;
      $display("FAIL fill_held got count=%0d head=%0d exp 4 10", count, rf_addr);
    end
    rf_ready = 1'b1;
    tick();
    wr_valid = 1'b0;
    checks++;
    if (count !== 3'd3 || full !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_no_push got count=%0d full=%b exp 3 0", count, full);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    push(3'd1, 5'd1);
    push(3'd3, 5'd2);
    rf_ready = 1'b1;
    wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      src_data[(i % NUM_SRC)*DATA_W +: DATA_W] = 32'hB000_0000 + 32'(i);
      sel     = 3'(i % NUM_SRC);
      wr_addr = 5'(3 + i);
      tick();
      checks++;
      if (count !== 3'd2) begin
        failures++;
        $display("FAIL b2b_count cycle=%0d got=%0d exp=2", i, count);
      end
    end
    wr_valid = 1'b0;
    drain();
  endtask

  task automatic test_zero_and_sel();
    push(3'd1, 5'd0);
    checks++;
    if (count !== 3'd0 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL zero_discard got count=%0d we=%b exp 0 0", count, rf_we);
    end
    checks++;
    if (sel_err !== 1'b0) begin
      failures++;
      $display("FAIL sel_err_clear got=%b exp=0", sel_err);
    end
    push(3'd7, 5'd3);
    checks++;
    if (rf_data !== 32'd0 || rf_addr !== 5'd3 || sel_err !== m_sel_err || m_sel_err !== 1'b1) begin
      failures++;
      $display("FAIL bad_sel got data=%h addr=%0d err=%b exp 0 3 1", rf_data, rf_addr, sel_err);
    end
    drain();
    push(3'd0, 5'd4);
    drain();
    checks++;
    if (sel_err !== 1'b1) begin
      failures++;
      $display("FAIL sel_err_sticky got=%b exp=1", sel_err);
    end
  endtask

  task automatic test_fwd();
    src_data[0*DATA_W +: DATA_W] = 32'h0000_0011;
    src_data[1*DATA_W +: DATA_W] = 32'h0000_0022;
    src_data[2*DATA_W +: DATA_W] = 32'h0000_0033;
    push(3'd0, 5'd5);
    push(3'd1, 5'd5);
    push(3'd2, 5'd7);
    fwd_addr = 5'd5;
    #1;
    checks++;
`ifdef WB_QUEUE_FWD_EN
    if (fwd_hit !== 1'b1 || fwd_data !== 32'h0000_0022) begin
      failures++;
      $display("FAIL fwd_youngest got hit=%b data=%h exp 1 00000022", fwd_hit, fwd_data);
    end
`else
    if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
      failures++;
      $display("FAIL fwd_disabled got hit=%b data=%h exp 0 0", fwd_hit, fwd_data);
    end
`endif
    fwd_addr = 5'd0;
    #1;
    checks++;
    if (fwd_hit !== 1'b0) begin
      failures++;
      $display("FAIL fwd_zero got hit=%b exp 0", fwd_hit);
    end
    drain();
  endtask

  task automatic test_async_reset();
    push(3'd1, 5'd11);
    push(3'd2, 5'd12);
    push(3'd3, 5'd13);
    #3;
    reset_n = 1'b0;
    #1;
    sb.delete();
    m_sel_err = 1'b0;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || rf_we !== 1'b0 || wr_ready !== 1'b1 ||
        sel_err !== 1'b0 || rf_data !== 32'd0) begin
      failures++;
      $display("FAIL async_reset got count=%0d empty=%b we=%b rdy=%b err=%b data=%h",
               count, empty, rf_we, wr_ready, sel_err, rf_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    src_data[4*DATA_W +: DATA_W] = 32'hC0FF_EE00;
    push(3'd4, 5'd30);
    checks++;
    if (count !== 3'd1 || rf_addr !== 5'd30 || rf_data !== 32'hC0FF_EE00) begin
      failures++;
      $display("FAIL post_reset_push got count=%0d addr=%0d data=%h exp 1 30 c0ffee00",
               count, rf_addr, rf_data);
    end
    drain();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    m_sel_err = 1'b0;
    src_data  = '0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_zero_and_sel();
    test_fwd();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
